// File: rtl/uart_line_echo.sv
// Line-editing echo stage between UART RX and TX: buffers a line with backspace
// support, then replays it followed by CR LF through the transmitter handshake.
module uart_line_echo #(
    parameter int DEPTH        = 32,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    tx_busy,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    tx_en,
    output logic [7:0]              line_len,
    output logic                    sending,
    output logic                    overflow,
    output logic                    dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_GUARD   = 2'd2;
    localparam logic [1:0] S_WAIT    = 2'd3;

    localparam logic [1:0] PH_LINE = 2'd0;
    localparam logic [1:0] PH_CR   = 2'd1;
    localparam logic [1:0] PH_LF   = 2'd2;

    localparam logic [PAYLOAD_BITS-1:0] CHAR_CR  = PAYLOAD_BITS'(8'h0D);
    localparam logic [PAYLOAD_BITS-1:0] CHAR_LF  = PAYLOAD_BITS'(8'h0A);
    localparam logic [PAYLOAD_BITS-1:0] CHAR_BS  = PAYLOAD_BITS'(8'h08);
    localparam logic [PAYLOAD_BITS-1:0] CHAR_DEL = PAYLOAD_BITS'(8'h7F);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [1:0]              state;
    logic [1:0]              phase;
    logic [AW:0]             count;
    logic [AW-1:0]           rd_idx;
    logic [PAYLOAD_BITS-1:0] line_buf [DEPTH];
    logic [PAYLOAD_BITS-1:0] issue_byte;

    logic is_cr;
    logic is_lf;
    logic is_bs;
    logic is_full;
    logic wr_en;
    logic last_byte;

    assign is_cr   = (rx_data == CHAR_CR);
    assign is_lf   = (rx_data == CHAR_LF);
    assign is_bs   = (rx_data == CHAR_BS) || (rx_data == CHAR_DEL);
    assign is_full = (count == FULL);
    assign wr_en   = (state == S_COLLECT) && rx_valid && !is_cr && !is_lf
                     && !is_bs && !is_full;

    // rd_idx has reached the final buffered byte of the line
    assign last_byte = ({1'b0, rd_idx} == (count - CNT_ONE));

    assign line_len = 8'(count);
    assign sending  = (state != S_COLLECT);

    always_comb begin
        issue_byte = line_buf[rd_idx];
        case (phase)
            PH_CR:   issue_byte = CHAR_CR;
            PH_LF:   issue_byte = CHAR_LF;
            default: issue_byte = line_buf[rd_idx];
        endcase
    end

    // Buffer storage carries no reset; only count decides what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            line_buf[count[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_COLLECT;
            phase    <= PH_LINE;
            count    <= '0;
            rd_idx   <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            tx_en   <= 1'b0;
            dropped <= rx_valid && (state != S_COLLECT);

            case (state)
                S_COLLECT: begin
                    if (rx_valid) begin
                        if (is_cr) begin
                            state  <= S_ISSUE;
                            rd_idx <= '0;
                            // An empty line goes straight to the CR LF trailer
                            phase  <= (count == '0) ? PH_CR : PH_LINE;
                        end else if (is_lf) begin
                            state <= S_COLLECT;
                        end else if (is_bs) begin
                            if (count != '0) begin
                                count <= count - CNT_ONE;
                            end
                        end else if (!is_full) begin
                            count <= count + CNT_ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!tx_busy) begin
                        tx_data <= issue_byte;
                        tx_en   <= 1'b1;
                        state   <= S_GUARD;
                    end
                end

                // Transmitter raises busy one cycle after tx_en; skip that cycle.
                S_GUARD: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (!tx_busy) begin
                        case (phase)
                            PH_LINE: begin
                                if (last_byte) begin
                                    phase <= PH_CR;
                                end else begin
                                    rd_idx <= rd_idx + IDX_ONE;
                                end
                                state <= S_ISSUE;
                            end
                            PH_CR: begin
                                phase <= PH_LF;
                                state <= S_ISSUE;
                            end
                            default: begin
                                count    <= '0;
                                overflow <= 1'b0;
                                phase    <= PH_LINE;
                                rd_idx   <= '0;
                                state    <= S_COLLECT;
                            end
                        endcase
                    end
                end

                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo (DEPTH=4) with a simple busy-counting TX model.
module tb_uart_line_echo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_en;
    logic [7:0] line_len;
    logic       sending;
    logic       overflow;
    logic       dropped;

    int n_cmp = 0;
    int n_err = 0;

    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] txq [$];
    logic [7:0] exp_q [$];
    int         en_busy_viol = 0;
    int         en_b2b_viol = 0;
    logic       prev_en = 1'b0;

    uart_line_echo #(.DEPTH(4), .PAYLOAD_BITS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .line_len (line_len),
        .sending  (sending),
        .overflow (overflow),
        .dropped  (dropped)
    );

    always #5 clock = ~clock;

    // TX model: busy rises the cycle after tx_en and stays high for 10 cycles
    always @(posedge clock) begin
        if (reset) busy_cnt <= 0;
        else if (tx_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    always @(negedge clock) begin
        if (tx_en) begin
            txq.push_back(tx_data);
            if (tx_busy) en_busy_viol++;
            if (prev_en) en_b2b_viol++;
        end
        prev_en = tx_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (sending && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_idle"}, 32'(sending), 32'h0);
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_count"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < txq.size()) check($sformatf("%s_byte%0d", tag, i), 32'(txq[i]), 32'(exp_q[i]));
        end
        check({tag, "_en_while_busy"}, 32'(en_busy_viol), 32'h0);
        check({tag, "_en_back2back"}, 32'(en_b2b_viol), 32'h0);
        txq.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_tx_en", 32'(tx_en), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_sending", 32'(sending), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_dropped", 32'(dropped), 32'h0);
        check("rst_line_len", 32'(line_len), 32'h0);

        // "Hi" CR
        send_byte(8'h48);
        send_byte(8'h69);
        check("hi_len", 32'(line_len), 32'd2);
        send_byte(8'h0D);
        check("hi_sending", 32'(sending), 32'h1);
        wait_idle("hi");
        exp_q = '{8'h48, 8'h69, 8'h0D, 8'h0A};
        check_tx("hi");
        check("hi_len_after", 32'(line_len), 32'h0);

        // Backspace editing
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h08);
        check("bs_len", 32'(line_len), 32'd1);
        send_byte(8'h63);
        send_byte(8'h0D);
        wait_idle("bs");
        exp_q = '{8'h61, 8'h63, 8'h0D, 8'h0A};
        check_tx("bs");
        send_byte(8'h08);
        check("bs_empty_len", 32'(line_len), 32'h0);
        send_byte(8'h7F);
        check("del_empty_len", 32'(line_len), 32'h0);

        // Overflow at DEPTH=4
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h64);
        check("ovf_len_full", 32'(line_len), 32'd4);
        check("ovf_before", 32'(overflow), 32'h0);
        send_byte(8'h65);
        check("ovf_after_e", 32'(overflow), 32'h1);
        check("ovf_len_e", 32'(line_len), 32'd4);
        send_byte(8'h66);
        check("ovf_len_f", 32'(line_len), 32'd4);
        send_byte(8'h0D);
        check("ovf_held_sending", 32'(overflow), 32'h1);
        wait_idle("ovf");
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
        check_tx("ovf");
        check("ovf_cleared", 32'(overflow), 32'h0);
        check("ovf_len_after", 32'(line_len), 32'h0);

        // Empty line CR LF: LF is dropped, only the trailer goes out
        send_byte(8'h0D);
        send_byte(8'h0A);
        wait_idle("empty");
        repeat (30) @(negedge clock);
        exp_q = '{8'h0D, 8'h0A};
        check_tx("empty");

        // Byte arriving during a send is dropped
        send_byte(8'h7A);
        send_byte(8'h0D);
        repeat (5) @(negedge clock);
        rx_data  = 8'h78;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        check("drop_pulse", 32'(dropped), 32'h1);
        check("drop_len_mid", 32'(line_len), 32'd1);
        @(negedge clock);
        check("drop_pulse_end", 32'(dropped), 32'h0);
        wait_idle("drop");
        exp_q = '{8'h7A, 8'h0D, 8'h0A};
        check_tx("drop");
        check("drop_len_after", 32'(line_len), 32'h0);

        // Busy hold, then reset during the third byte
        hold_busy = 1'b1;
        send_byte(8'h70);
        send_byte(8'h71);
        send_byte(8'h72);
        send_byte(8'h0D);
        repeat (20) @(negedge clock);
        check("hold_no_tx", 32'(txq.size()), 32'h0);
        check("hold_sending", 32'(sending), 32'h1);
        hold_busy = 1'b0;
        begin
            int cyc = 0;
            while (txq.size() < 3 && cyc < 3000) begin
                @(negedge clock);
                #1;
                cyc++;
            end
        end
        check("mid_third", 32'(txq.size()), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tx_en", 32'(tx_en), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_sending", 32'(sending), 32'h0);
        check("mid_rst_line_len", 32'(line_len), 32'h0);
        check("mid_rst_overflow", 32'(overflow), 32'h0);
        check("mid_rst_dropped", 32'(dropped), 32'h0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        exp_q = '{8'h70, 8'h71, 8'h72};
        check_tx("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
